therm_accum: RTL and testbench
==============================

Name: therm_accum

Overview:
- Sits directly downstream of the sorter network (sorter2b/sorter3b style).
- Consumes one sorted thermometer vector per accepted beat, where the ones are packed at the MSB end.
- Converts each beat to a binary count and accumulates the counts over a frame, delimited by in_last.
- Presents the saturating frame total on a valid/ready output register, with saturation and bubble-error flags.

Parameters:
- N, 3, thermometer input width; legal range N >= 2.
- CNT_W, 8, accumulator and output width; legal range CNT_W >= clog2(N+1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- in_therm  input  N  sorter output, thermometer code.
- in_last  input  1  beat is the final beat of its frame.
- out_valid  output  1  frame result valid.
- out_ready  input  1  consumer accepts the result.
- out_count  output  CNT_W  frame total (saturated).
- out_sat  output  1  frame total saturated.
- out_bubble  output  1  frame contained at least one non-thermometer beat.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values:
  - out_valid=0, out_count=0, out_sat=0, out_bubble=0.
  - Accumulator=0; internal sat and bubble flags=0.
  - in_ready=1 once rst_n is deasserted.
- Reset mid-operation:
  - Asserting rst_n clears all state immediately, without waiting for a clock edge.
  - A partial frame is discarded.
  - A pending output is dropped.
- Legal input codes: ones packed from MSB downward. For N=3 the legal codes are 000, 100, 110, 111.
- Beat count:
  - Count = popcount(in_therm), range 0..N.
  - Bubble = any i with in_therm[i]=1 and in_therm[i+1]=0.
  - A bubble beat is still counted by popcount and sets the frame bubble flag.
- Handshake:
  - A beat transfers on in_valid && in_ready.
  - in_ready = !out_valid || out_ready. This is combinational from out_ready and out_valid; there is no skid buffer.
  - in_therm and in_last are ignored when no transfer occurs.
- Accumulation on a transfer with in_last=0:
  - acc <= min(acc + count, 2^CNT_W - 1), computed at width CNT_W+1 and then clamped.
  - The sat flag is set if the clamp engaged.
  - The bubble flag is ORed with the beat's bubble.
- Frame end, on a transfer with in_last=1:
  - out_count <= the clamped value of acc + count.
  - out_sat <= sat flag OR this beat's clamp.
  - out_bubble <= bubble flag OR this beat's bubble.
  - out_valid <= 1.
  - Accumulator, sat flag and bubble flag clear to 0 in the same cycle.
- Latency: the result is visible one cycle after the last beat transfers.
- State machine, 2 states:
  - ACCUM (out_valid=0): accept beats. A last-beat transfer goes to HOLD.
  - HOLD (out_valid=1): out_count, out_sat and out_bubble are held stable while out_ready=0.
  - HOLD with out_ready=1: result consumed.
    - Same-cycle beat transfer with in_last=1: stay in HOLD with the new result.
    - Same-cycle beat transfer with in_last=0: that beat accumulates; go to ACCUM.
    - No transfer: go to ACCUM. Output fields keep their value; only out_valid drops.
- Single-beat frames (in_last=1 on the first beat) are legal.
- An all-zero frame yields out_count=0 with out_valid=1.
- Saturation is sticky for the remainder of the frame. Later beats cannot wrap the accumulator.

Test Plan:
- Basic frame: N=3, CNT_W=8, beats 100, 110, 111 (last on the third), out_ready=1 -> one cycle after the third beat: out_valid=1, out_count=6, out_sat=0, out_bubble=0; next cycle out_valid=0.
- Single/zero frame: one beat 000 with in_last=1 -> out_valid=1, out_count=0; then beat 111 with in_last=1 -> out_count=3.
- Backpressure: frame 111, 111 (last) while out_ready=0 for 3 cycles, next beat 100 held valid ->
  - in_ready=0 and out_count=6 stable for all 3 cycles.
  - The cycle out_ready=1: the 100 beat transfers in the same cycle and in_ready=1.
- Saturation: 90 beats of 111 then one 111 with in_last=1 -> out_count=255, out_sat=1; following frame 110 (last) -> out_count=2, out_sat=0.
- Bubble: frame 010, 100 (last) -> out_count=2, out_bubble=1; next frame 100 (last) -> out_bubble=0.
- Async reset: after 2 accepted 111 beats, pull rst_n low mid-cycle -> all outputs 0 before the next edge; release, send 110 (last) -> out_count=2.

Source files
------------

// File: rtl/therm_accum.sv
// Thermometer-code accumulator: counts each sorted beat, sums over a frame,
// and holds the saturating total with sat/bubble flags on a valid/ready output.
module therm_accum #(
   parameter int N     = 3,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_therm,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] out_count,
   output logic             out_sat,
   output logic             out_bubble
);

   typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_acc;
   logic               r_sat;
   logic               r_bub;
   logic [CNT_W-1:0]   r_out_count;
   logic               r_out_sat;
   logic               r_out_bub;

   logic               w_in_ready;
   logic               w_xfer;
   logic [CNT_W:0]     w_sum;
   logic [CNT_W-1:0]   w_clamped;
   logic               w_clip;
   logic               w_beat_bub;

   function automatic logic [CNT_W:0] popcnt(input logic [N-1:0] t);
      logic [CNT_W:0] c;
      c = '0;
      for (int i = 0; i < N; i++) begin
         c = c + (CNT_W+1)'(t[i]);
      end
      return c;
   endfunction

   // A one below a zero means the ones are not packed at the MSB end.
   function automatic logic has_bubble(input logic [N-1:0] t);
      logic b;
      b = 1'b0;
      for (int i = 0; i < N-1; i++) begin
         b = b | (t[i] & ~t[i+1]);
      end
      return b;
   endfunction

   function automatic logic [CNT_W-1:0] sat_clamp(input logic [CNT_W:0] s);
      return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
   endfunction

   assign w_in_ready = (r_state == ACCUM) || out_ready;
   assign w_xfer     = in_valid && w_in_ready;
   assign w_sum      = {1'b0, r_acc} + popcnt(in_therm);
   assign w_clamped  = sat_clamp(w_sum);
   assign w_clip     = w_sum[CNT_W];
   assign w_beat_bub = has_bubble(in_therm);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ACCUM;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ACCUM: if (w_xfer && in_last) w_state_nxt = HOLD;
         HOLD:  if (out_ready) w_state_nxt = (w_xfer && in_last) ? HOLD : ACCUM;
         default: w_state_nxt = ACCUM;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc       <= '0;
         r_sat       <= 1'b0;
         r_bub       <= 1'b0;
         r_out_count <= '0;
         r_out_sat   <= 1'b0;
         r_out_bub   <= 1'b0;
      end else if (w_xfer) begin
         if (in_last) begin
            r_out_count <= w_clamped;
            r_out_sat   <= r_sat | w_clip;
            r_out_bub   <= r_bub | w_beat_bub;
            r_acc       <= '0;
            r_sat       <= 1'b0;
            r_bub       <= 1'b0;
         end else begin
            r_acc <= w_clamped;
            r_sat <= r_sat | w_clip;
            r_bub <= r_bub | w_beat_bub;
         end
      end
   end

   assign in_ready   = w_in_ready;
   assign out_valid  = (r_state == HOLD);
   assign out_count  = r_out_count;
   assign out_sat    = r_out_sat;
   assign out_bubble = r_out_bub;

endmodule

// File: tb/tb_therm_accum.sv
// Directed-vector bench for therm_accum (N=3, CNT_W=8) with hand-computed totals.
module tb_therm_accum;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_therm;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_count;
   logic       out_sat;
   logic       out_bubble;

   int n_total;
   int n_bad;

   therm_accum #(.N(3), .CNT_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_therm   (in_therm),
      .in_last    (in_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_count  (out_count),
      .out_sat    (out_sat),
      .out_bubble (out_bubble)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Present one beat at the falling edge; it transfers on the next rising edge.
   task automatic send(input logic [2:0] t, input logic last);
      @(negedge clk);
      in_valid = 1'b1;
      in_therm = t;
      in_last  = last;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      n_total   = 0;
      n_bad     = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_therm  = 3'b000;
      in_last   = 1'b0;
      out_ready = 1'b0;

      #2;
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_count", 32'(out_count), 0);
      chk("rst_sat",   32'(out_sat), 0);
      chk("rst_bub",   32'(out_bubble), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", 32'(in_ready), 1);
      out_ready = 1'b1;

      // basic frame 100,110,111 -> 6
      send(3'b100, 1'b0);
      send(3'b110, 1'b0);
      send(3'b111, 1'b1);
      @(negedge clk);
      chk("basic_valid", 32'(out_valid), 1);
      chk("basic_count", 32'(out_count), 6);
      chk("basic_sat",   32'(out_sat), 0);
      chk("basic_bub",   32'(out_bubble), 0);
      @(negedge clk);
      chk("basic_drop",  32'(out_valid), 0);
      chk("basic_keep",  32'(out_count), 6);

      // single-beat frames
      send(3'b000, 1'b1);
      @(negedge clk);
      chk("zero_valid", 32'(out_valid), 1);
      chk("zero_count", 32'(out_count), 0);
      send(3'b111, 1'b1);
      @(negedge clk);
      chk("single_count", 32'(out_count), 3);

      // backpressure with the next beat waiting
      send(3'b111, 1'b0);
      send(3'b111, 1'b1);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_therm  = 3'b100;
      in_last   = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(in_ready), 0);
         chk("bp_valid",    32'(out_valid), 1);
         chk("bp_count",    32'(out_count), 6);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(in_ready), 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp_after_valid", 32'(out_valid), 0);
      send(3'b110, 1'b1);
      @(negedge clk);
      chk("bp_carry_count", 32'(out_count), 3);

      // back-to-back last beats while the consumer is ready
      send(3'b111, 1'b1);
      send(3'b110, 1'b1);
      @(negedge clk);
      chk("b2b_valid", 32'(out_valid), 1);
      chk("b2b_count", 32'(out_count), 2);

      // saturation: 91 beats of 111 = 273 -> 255
      for (int k = 0; k < 90; k++) send(3'b111, 1'b0);
      send(3'b111, 1'b1);
      @(negedge clk);
      chk("sat_count", 32'(out_count), 255);
      chk("sat_flag",  32'(out_sat), 1);
      send(3'b110, 1'b1);
      @(negedge clk);
      chk("sat_next_count", 32'(out_count), 2);
      chk("sat_next_flag",  32'(out_sat), 0);

      // bubble
      send(3'b010, 1'b0);
      send(3'b100, 1'b1);
      @(negedge clk);
      chk("bub_count", 32'(out_count), 2);
      chk("bub_flag",  32'(out_bubble), 1);
      send(3'b100, 1'b1);
      @(negedge clk);
      chk("bub_next_count", 32'(out_count), 1);
      chk("bub_next_flag",  32'(out_bubble), 0);

      // asynchronous reset mid-frame with a prior result still present
      send(3'b111, 1'b0);
      send(3'b111, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(out_valid), 0);
      chk("arst_count", 32'(out_count), 0);
      chk("arst_sat",   32'(out_sat), 0);
      chk("arst_bub",   32'(out_bubble), 0);
      @(negedge clk);
      rst_n = 1'b1;
      send(3'b110, 1'b1);
      @(negedge clk);
      chk("arst_after_valid", 32'(out_valid), 1);
      chk("arst_after_count", 32'(out_count), 2);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
